// File: rtl/fifo_param.sv
// Parametrised single-clock FIFO with registered read data, registered
// accept/reject pulses, level flags and an observable request-decision FSM.
module fifo_param #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3,
    parameter int AF_LVL = 6,
    parameter int AE_LVL = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] din,
    input  logic              rd_en,
    output logic [DATA_W-1:0] dout,
    output logic [ADDR_W:0]   data_count,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic              wr_ack,
    output logic              wr_err,
    output logic              rd_ack,
    output logic              rd_err,
    output logic [2:0]        state
);

    localparam int              DEPTH   = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] AF_C    = (ADDR_W + 1)'(AF_LVL);
    localparam logic [ADDR_W:0] AE_C    = (ADDR_W + 1)'(AE_LVL);

    localparam logic [2:0] ST_INIT     = 3'b000;
    localparam logic [2:0] ST_NO_OP    = 3'b001;
    localparam logic [2:0] ST_WRITE    = 3'b010;
    localparam logic [2:0] ST_WR_ERROR = 3'b011;
    localparam logic [2:0] ST_READ     = 3'b100;
    localparam logic [2:0] ST_RD_ERROR = 3'b101;
    localparam logic [2:0] ST_WR_RD    = 3'b110;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              wr_ack_q, wr_ack_d, wr_err_q, wr_err_d;
    logic              rd_ack_q, rd_ack_d, rd_err_q, rd_err_d;
    logic [2:0]        state_q, state_d;
    logic              wr_ok, rd_ok;

    // Handshake: wr_en/rd_en are requests sampled every edge with no ready;
    // the edge that samples a request answers it one cycle later with exactly
    // one of ack (accepted) or err (rejected: full for writes, empty for reads).
    always_comb begin
        wr_ok    = wr_en && (count_q != DEPTH_C);
        rd_ok    = rd_en && (count_q != '0);
        wr_ptr_d = wr_ok ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
        rd_ptr_d = rd_ok ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;
        count_d  = count_q + (ADDR_W + 1)'(wr_ok) - (ADDR_W + 1)'(rd_ok);
        dout_d   = rd_ok ? mem[rd_ptr_q] : dout_q;
        wr_ack_d = wr_ok;
        wr_err_d = wr_en && !wr_ok;
        rd_ack_d = rd_ok;
        rd_err_d = rd_en && !rd_ok;

        // Next state reflects only this edge's decision, never the current state.
        state_d = ST_NO_OP;
        if (wr_en && rd_en) begin
            if (wr_ok && rd_ok) state_d = ST_WR_RD;
            else if (wr_ok)     state_d = ST_WRITE;
            else                state_d = ST_READ;
        end else if (wr_en) begin
            state_d = wr_ok ? ST_WRITE : ST_WR_ERROR;
        end else if (rd_en) begin
            state_d = rd_ok ? ST_READ : ST_RD_ERROR;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            dout_q   <= '0;
            wr_ack_q <= 1'b0;
            wr_err_q <= 1'b0;
            rd_ack_q <= 1'b0;
            rd_err_q <= 1'b0;
            state_q  <= ST_INIT;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            dout_q   <= dout_d;
            wr_ack_q <= wr_ack_d;
            wr_err_q <= wr_err_d;
            rd_ack_q <= rd_ack_d;
            rd_err_q <= rd_err_d;
            state_q  <= state_d;
        end
    end

    // Storage is deliberately not reset; the pointers alone define contents.
    always_ff @(posedge clk) begin
        if (reset_n && wr_ok) begin
            mem[wr_ptr_q] <= din;
        end
    end

    assign dout         = dout_q;
    assign data_count   = count_q;
    assign full         = (count_q == DEPTH_C);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= AF_C);
    assign almost_empty = (count_q <= AE_C);
    assign wr_ack       = wr_ack_q;
    assign wr_err       = wr_err_q;
    assign rd_ack       = rd_ack_q;
    assign rd_err       = rd_err_q;
    assign state        = state_q;

endmodule

// File: tb/tb_fifo_param.sv
// Bench for fifo_param: directed scenarios plus random traffic, every edge
// compared against a queue-based reference of the FIFO's contents.
module tb_fifo_param;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 3;
    localparam int DEPTH  = 8;
    localparam int AF_LVL = 6;
    localparam int AE_LVL = 2;

    localparam logic [2:0] S_INIT     = 3'd0;
    localparam logic [2:0] S_NO_OP    = 3'd1;
    localparam logic [2:0] S_WRITE    = 3'd2;
    localparam logic [2:0] S_WR_ERROR = 3'd3;
    localparam logic [2:0] S_READ     = 3'd4;
    localparam logic [2:0] S_RD_ERROR = 3'd5;
    localparam logic [2:0] S_WR_RD    = 3'd6;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              wr_en = 1'b0;
    logic              rd_en = 1'b0;
    logic [DATA_W-1:0] din = '0;
    logic [DATA_W-1:0] dout;
    logic [ADDR_W:0]   data_count;
    logic              full, empty, almost_full, almost_empty;
    logic              wr_ack, wr_err, rd_ack, rd_err;
    logic [2:0]        state;

    fifo_param #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .AF_LVL(AF_LVL), .AE_LVL(AE_LVL)
    ) dut (
        .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .din(din), .rd_en(rd_en),
        .dout(dout), .data_count(data_count), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty),
        .wr_ack(wr_ack), .wr_err(wr_err), .rd_ack(rd_ack), .rd_err(rd_err),
        .state(state)
    );

    always #5 clk = ~clk;

    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] exp_dout = '0;
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input logic ea, input logic ee, input logic ra,
                             input logic re, input logic [2:0] st);
        int c;
        c = exp_q.size();
        check("dout", 32'(dout), 32'(exp_dout));
        check("data_count", 32'(data_count), c);
        check("full", 32'(full), 32'(c == DEPTH));
        check("empty", 32'(empty), 32'(c == 0));
        check("almost_full", 32'(almost_full), 32'(c >= AF_LVL));
        check("almost_empty", 32'(almost_empty), 32'(c <= AE_LVL));
        check("wr_ack", 32'(wr_ack), 32'(ea));
        check("wr_err", 32'(wr_err), 32'(ee));
        check("rd_ack", 32'(rd_ack), 32'(ra));
        check("rd_err", 32'(rd_err), 32'(re));
        check("state", 32'(state), 32'(st));
    endtask

    task automatic step(input logic w, input logic r, input logic [DATA_W-1:0] d);
        int c;
        logic wok, rok;
        logic [2:0] st;
        @(negedge clk);
        wr_en = w;
        rd_en = r;
        din   = d;
        c   = exp_q.size();
        wok = w && (c < DEPTH);
        rok = r && (c > 0);
        if (rok) exp_dout = exp_q.pop_front();
        if (wok) exp_q.push_back(d);
        if (!w && !r)    st = S_NO_OP;
        else if (w && r) st = (wok && rok) ? S_WR_RD : (wok ? S_WRITE : S_READ);
        else if (w)      st = wok ? S_WRITE : S_WR_ERROR;
        else             st = rok ? S_READ : S_RD_ERROR;
        @(posedge clk);
        #1;
        check_all(wok, w && !wok, rok, r && !rok, st);
    endtask

    task automatic do_reset(input logic w);
        @(negedge clk);
        reset_n = 1'b0;
        wr_en   = w;
        rd_en   = 1'b0;
        din     = 8'h5C;
        exp_q.delete();
        exp_dout = '0;
        @(posedge clk);
        #1;
        check_all(1'b0, 1'b0, 1'b0, 1'b0, S_INIT);
        @(negedge clk);
        reset_n = 1'b1;
        wr_en   = 1'b0;
    endtask

    initial begin
        int wr_pct, rd_pct;

        // 1: reset, then a read from empty
        do_reset(1'b0);
        step(1'b0, 1'b1, 8'h00);

        // 2: fill with 0x01..0x08, then overflow attempt
        for (int i = 1; i <= DEPTH; i++) step(1'b1, 1'b0, 8'(i));
        step(1'b1, 1'b0, 8'hEE);

        // 3: drain in order, ending with an idle edge
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b0, 8'h00);

        // 4: hold at 4 entries while reading and writing together
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'(8'h10 + i));
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 8'(8'h20 + i));
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'h00);

        // 5: simultaneous requests at the empty and full boundaries
        step(1'b1, 1'b1, 8'hAA);
        for (int i = 0; i < DEPTH - 1; i++) step(1'b1, 1'b0, 8'(8'h40 + i));
        step(1'b1, 1'b1, 8'hBB);
        for (int i = 0; i < DEPTH - 1; i++) step(1'b0, 1'b1, 8'h00);

        // 6: reset mid-operation with a write pending
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(8'h60 + i));
        do_reset(1'b1);
        step(1'b0, 1'b1, 8'h00);

        // Random traffic in phases with shifting read/write bias
        for (int p = 0; p < 8; p++) begin
            wr_pct = $urandom_range(20, 90);
            rd_pct = $urandom_range(20, 90);
            for (int i = 0; i < 60; i++) begin
                step(($urandom_range(0, 99) < wr_pct), ($urandom_range(0, 99) < rd_pct),
                     8'($urandom));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
